// File: rtl/regfile_pkg.sv
// Shared defaults and state encoding for the register-file write arbiter.
package regfile_pkg;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NREG       = 2 ** ADDR_W_DEF;

  typedef enum logic {
    INIT,
    RUN
  } state_e;
endpackage

// File: rtl/regfile_wr_arb_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt
);

  // req[0]/gnt[0] is requester A, req[1]/gnt[1] is B; last=1 means B won last.
  always_comb begin
    gnt = '0;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wr_arb.sv
// Register-file write arbiter: zero-fill sweep after reset/clear, then
// round-robin arbitration of two write requesters into one write port.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  state_e              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                last_q;
  logic                busy_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                arb_en;
  logic [1:0]          gnt;

  assign arb_en = (state_q == RUN) && !clr && !rst;

  rr_arb2 u_arb (
    .req  ({req_b, req_a}),
    .last (last_q),
    .en   (arb_en),
    .gnt  (gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      cnt_q     <= '0;
      busy_q    <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      last_q    <= 1'b1;
    end else if (clr) begin
      // Clear only rewinds the sweep; the last write's addr/data are held.
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      wr_en_q <= 1'b0;
    end else begin
      unique case (state_q)
        INIT: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= cnt_q;
          wr_data_q <= '0;
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          wr_en_q <= |gnt;
          if (gnt[0]) begin
            wr_addr_q <= addr_a;
            wr_data_q <= data_a;
            last_q    <= 1'b0;
          end else if (gnt[1]) begin
            wr_addr_q <= addr_b;
            wr_data_q <= data_b;
            last_q    <= 1'b1;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign gnt_a   = gnt[0];
  assign gnt_b   = gnt[1];
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Self-checking bench for regfile_wr_arb against a behavioural model.
module tb_regfile_wr_arb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst, clr, req_a, req_b;
  logic [AW-1:0] addr_a, addr_b, wr_addr;
  logic [DW-1:0] data_a, data_b, wr_data;
  logic          gnt_a, gnt_b, wr_en, busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Behavioural model: sweep progress, last winner (0=A, 1=B), expected outputs.
  bit            m_sweep;
  int            m_next;
  int            m_last;
  bit            m_busy;
  bit            m_wr_en;
  int            m_wr_addr;
  logic [DW-1:0] m_wr_data;
  int            cur_win;

  always #5 clk = ~clk;

  regfile_wr_arb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .req_a   (req_a),
    .req_b   (req_b),
    .addr_a  (addr_a),
    .addr_b  (addr_b),
    .data_a  (data_a),
    .data_b  (data_b),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sweep   = 1'b1;
    m_next    = 0;
    m_busy    = 1'b1;
    m_wr_en   = 1'b0;
    m_wr_addr = 0;
    m_wr_data = '0;
    m_last    = 1;
  endtask

  // Inputs are already applied (after a negedge); check grants, clock, check registers.
  task automatic cycle();
    #1;
    cur_win = -1;
    if (!rst && !clr && !m_sweep) begin
      if (req_a && req_b) cur_win = (m_last == 0) ? 1 : 0;
      else if (req_a)     cur_win = 0;
      else if (req_b)     cur_win = 1;
    end
    check("gnt_a", gnt_a, cur_win == 0);
    check("gnt_b", gnt_b, cur_win == 1);
    check("gnt_exclusive", gnt_a & gnt_b, 0);
    check("gnt_while_busy", busy & (gnt_a | gnt_b), 0);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (clr) begin
      m_sweep = 1'b1;
      m_next  = 0;
      m_busy  = 1'b1;
      m_wr_en = 1'b0;
    end else if (m_sweep) begin
      m_wr_en   = 1'b1;
      m_wr_addr = m_next;
      m_wr_data = '0;
      m_next++;
      if (m_next == NR) begin
        m_sweep = 1'b0;
        m_busy  = 1'b0;
        m_next  = 0;
      end
    end else if (cur_win >= 0) begin
      m_wr_en   = 1'b1;
      m_wr_addr = (cur_win == 0) ? int'(addr_a) : int'(addr_b);
      m_wr_data = (cur_win == 0) ? data_a : data_b;
      m_last    = cur_win;
    end else begin
      m_wr_en = 1'b0;
    end
    #1;
    check("wr_en", wr_en, m_wr_en);
    check("wr_addr", wr_addr, m_wr_addr);
    check("wr_data", wr_data, m_wr_data);
    check("busy", busy, m_busy);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; req_a = 1'b0; req_b = 1'b0;
    addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    cycle();

    // Sweep after release, with noise on the request lines.
    rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      req_a = 1'($urandom); req_b = 1'($urandom);
      addr_a = AW'($urandom); addr_b = AW'($urandom);
      data_a = $urandom; data_b = $urandom;
      cycle();
    end
    req_a = 1'b0; req_b = 1'b0;
    cycle();

    // Single write from A.
    req_a = 1'b1; addr_a = 5'd5; data_a = 32'hDEADBEEF;
    cycle();
    req_a = 1'b0;
    cycle();
    cycle();

    // Back-to-back contention straight out of reset: A,B,A,B.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (NR) cycle();
    for (int i = 0; i < 4; i++) begin
      req_a = 1'b1; req_b = 1'b1;
      addr_a = AW'(i);      data_a = 32'hA000_0000 + i;
      addr_b = AW'(i + 16); data_b = 32'hB000_0000 + i;
      cycle();
    end
    req_a = 1'b0; req_b = 1'b0;
    cycle();

    // Clear coincident with a B request; B must be served right after the sweep.
    req_b = 1'b1; addr_b = 5'd9; data_b = 32'h1234_5678; clr = 1'b1;
    cycle();
    clr = 1'b0;
    repeat (NR) cycle();
    cycle();
    req_b = 1'b0;
    cycle();

    // Reset in the middle of a sweep, right after address 17 was written.
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    repeat (18) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (NR + 1) cycle();

    // Random handshaking traffic with occasional clear and reset.
    for (int i = 0; i < 600; i++) begin
      clr = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 149) == 0);
      cycle();
      if (cur_win == 0 || !req_a) begin
        req_a  = ($urandom_range(0, 2) != 0);
        addr_a = AW'($urandom);
        data_a = (i % 7 == 0) ? '0 : $urandom;
      end
      if (cur_win == 1 || !req_b) begin
        req_b  = ($urandom_range(0, 2) != 0);
        addr_b = AW'($urandom);
        data_b = (i % 11 == 0) ? '1 : $urandom;
      end
    end
    rst = 1'b0; clr = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arb.md
REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register address width; NREG = 2**ADDR_W, so 32 by default.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port clr  input  1  one-cycle pulse that restarts the clear sequence.
REQ-006 The block SHALL have ports req_a / req_b  input  1  write request from requester A / B.
REQ-007 The block SHALL have ports addr_a / addr_b  input  ADDR_W  target register of A / B.
REQ-008 The block SHALL have ports data_a / data_b  input  DATA_W  write data of A / B.
REQ-009 The block SHALL have ports gnt_a / gnt_b  output  1  combinational grant to A / B.
REQ-010 The block SHALL have port wr_en  output  1  registered write strobe; drives the register-file decoder enable.
REQ-011 The block SHALL have port wr_addr  output  ADDR_W  registered write address; drives the decoder select.
REQ-012 The block SHALL have port wr_data  output  DATA_W  registered write data.
REQ-013 The block SHALL have port busy  output  1  registered; high while the clear sequence runs.

Function
REQ-014 The FSM SHALL have two states, INIT and RUN.
REQ-015 In INIT, each rising edge SHALL register wr_en=1, wr_addr=cnt and wr_data=0, then increment cnt.
REQ-016 On the INIT edge with cnt=NREG-1, the FSM SHALL move to RUN, clear busy and wrap cnt to 0.
REQ-017 In INIT, gnt_a and gnt_b SHALL both be 0.
REQ-018 In RUN, a grant SHALL go to the only requester whose req is high.
REQ-019 In RUN with both req high, the grant SHALL go to the requester not granted last (round-robin via a last pointer).
REQ-020 At most one of gnt_a and gnt_b SHALL be high in any cycle.
REQ-021 Latency: a grant in cycle t SHALL produce wr_en=1 with the granted addr/data on the next edge, for exactly one cycle per grant.
REQ-022 The last pointer SHALL update only on the edge following a grant.
REQ-023 In RUN with no grant, the next edge SHALL register wr_en=0 and hold wr_addr and wr_data.
REQ-024 Handshake: a requester holds req, addr and data stable until it sees its gnt; one grant SHALL complete one write, and sustained req SHALL be granted on consecutive cycles.
REQ-025 clr high in RUN SHALL suppress both grants that cycle, enter INIT and set busy on the next edge, with cnt=0.
REQ-026 clr high in INIT SHALL restart the sweep from address 0.
REQ-027 A denied requester SHALL be granted within 2 cycles while in RUN, so neither requester starves.
REQ-028 Writes to every address, including 0, SHALL pass unmodified.

Reset
REQ-029 While rst is high at an edge, the block SHALL set state=INIT, cnt=0, busy=1, wr_en=0, wr_addr=0, wr_data=0 and last=B, so A wins the first tie.
REQ-030 rst SHALL take priority over clr and req.
REQ-031 rst asserted mid-sweep or mid-write SHALL abandon it; the sweep SHALL restart from 0 after release.
REQ-032 The first edge after rst release SHALL register wr_en=1 with wr_addr=0.

Structure
REQ-033 Shared package regfile_pkg SHALL hold DATA_W/ADDR_W defaults, NREG, and the state enum {INIT, RUN}.
REQ-034 Two-way round-robin grant logic SHALL be a sub-module rr_arb2 (inputs req[1:0], last, en; output gnt[1:0]).
REQ-035 The top SHALL hold the FSM, cnt, last pointer and output registers.

Verification
REQ-036 Reset then release -> wr_en high 32 consecutive cycles, wr_addr 0..31 in order, wr_data=0; busy falls after addr 31; no gnt during the sweep.
REQ-037 RUN, req_a only with addr_a=5, data_a=0xDEADBEEF -> gnt_a same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; then wr_en=0.
REQ-038 RUN, both req held for 4 cycles from reset state -> grants A,B,A,B; writes appear one cycle later in the same order.
REQ-039 RUN, clr pulse coincident with req_b -> gnt_b=0; busy=1 next edge; sweep 0..31 rewritten; req_b granted in the first RUN cycle.
REQ-040 rst asserted at sweep addr 17 for one cycle -> outputs zero; after release the sweep restarts at 0.
REQ-041 Assertions: never gnt_a&gnt_b; wr_en implies wr_addr<NREG; no gnt while busy.
